// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops fixed-length bursts from a show-ahead FIFO into a
// valid/ready stream. Define FIFO_BURST_READER_STATS_EN to add burst_cnt_o.

module fifo_burst_reader #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 4,
    parameter int BURST_LEN = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    input  logic              flush_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]       burst_cnt_o
`endif
);

    localparam logic [AWIDTH:0] BLEN = (AWIDTH+1)'(BURST_LEN);
    localparam logic [AWIDTH:0] ONE  = (AWIDTH+1)'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [AWIDTH:0]   remaining;
    logic              flush_pend;

    // second buffer slot, holds a popped word while the head is stalled
    logic              skid_valid;
    logic [DWIDTH-1:0] skid_data;
    logic              skid_last;

    logic [1:0]        buf_cnt;
    logic              xfer;
    logic              pop;
    logic              pop_last;
    logic              head_free;

    assign buf_cnt   = {1'b0, valid_o} + {1'b0, skid_valid};
    assign xfer      = valid_o & ready_i;
    assign head_free = ~valid_o | ready_i;
    assign pop_last  = (remaining == ONE);

    assign pop = srst_i
               & (state == BURST)
               & ~fifo_empty_i
               & (remaining != '0)
               & (buf_cnt < 2'd2);

    assign fifo_rdreq_o = pop;

    // burst sequencing: start on full fill or pending flush, end on last beat
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state      <= IDLE;
            remaining  <= '0;
            flush_pend <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fifo_usedw_i >= BLEN) begin
                        state      <= BURST;
                        remaining  <= BLEN;
                        flush_pend <= flush_pend | flush_i;
                    end else if (flush_pend && fifo_usedw_i == '0) begin
                        flush_pend <= flush_i;
                    end else if (flush_pend && !fifo_empty_i) begin
                        state      <= BURST;
                        remaining  <= fifo_usedw_i;
                        flush_pend <= flush_i;
                    end else begin
                        flush_pend <= flush_pend | flush_i;
                    end
                end
                BURST: begin
                    if (pop) begin
                        remaining <= remaining - ONE;
                    end
                    if (xfer && last_o) begin
                        state <= IDLE;
                    end
                    flush_pend <= flush_pend | flush_i;
                end
            endcase
        end
    end

    // two-entry output buffer: head drives the stream, skid catches a stall
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            valid_o    <= 1'b0;
            data_o     <= '0;
            last_o     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else begin
            if (head_free) begin
                if (skid_valid) begin
                    valid_o <= 1'b1;
                    data_o  <= skid_data;
                    last_o  <= skid_last;
                end else if (pop) begin
                    valid_o <= 1'b1;
                    data_o  <= fifo_q_i;
                    last_o  <= pop_last;
                end else begin
                    valid_o <= 1'b0;
                    last_o  <= 1'b0;
                end
            end
            if (!head_free && pop) begin
                skid_valid <= 1'b1;
                skid_data  <= fifo_q_i;
                skid_last  <= pop_last;
            end else if (head_free) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    // completed-burst counter, wraps naturally at 16 bits
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            burst_cnt_o <= '0;
        end else if (xfer && last_o) begin
            burst_cnt_o <= burst_cnt_o + 16'd1;
        end
    end
`endif

endmodule
